// File: rtl/regfile8_wb_arbiter.sv
// Writeback arbiter for the 8-entry register file: round-robin between ALU and
// load results, a registered write port, and a pending-write scoreboard.
module regfile8_wb_arbiter #(
   parameter int DW = 32,
   parameter int AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_v,
   input  logic [AW-1:0]     iss_rd,
   output logic              iss_ok,
   output logic [2**AW-1:0]  busy,
   output logic              waw_err,
   input  logic              alu_valid,
   input  logic [AW-1:0]     alu_rd,
   input  logic [DW-1:0]     alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [AW-1:0]     mem_rd,
   input  logic [DW-1:0]     mem_data,
   output logic              mem_ready,
   output logic              rf_we,
   output logic [AW-1:0]     rf_wa,
   output logic [DW-1:0]     rf_wd
);

   localparam int NR = 2**AW;
   localparam logic [NR-1:0] BUSY_MASK = {{(NR-1){1'b1}}, 1'b0};

   logic              pref_mem;
   logic              alu_gnt_p0;
   logic              mem_gnt_p0;
   logic              vld_p0;
   logic [AW-1:0]     win_rd_p0;
   logic [DW-1:0]     win_data_p0;
   logic [NR-1:0]     busy_set;
   logic [NR-1:0]     busy_clr;
   logic              iss_wr;

   // Stage p0: combinational grant; pref_mem names the side that wins a tie
   always_comb begin
      alu_gnt_p0 = 1'b0;
      mem_gnt_p0 = 1'b0;
      if (!rst) begin
         if (alu_valid && mem_valid) begin
            mem_gnt_p0 = pref_mem;
            alu_gnt_p0 = !pref_mem;
         end else begin
            alu_gnt_p0 = alu_valid;
            mem_gnt_p0 = mem_valid;
         end
      end
   end

   assign alu_ready   = alu_gnt_p0;
   assign mem_ready   = mem_gnt_p0;
   assign vld_p0      = alu_gnt_p0 || mem_gnt_p0;
   assign win_rd_p0   = mem_gnt_p0 ? mem_rd   : alu_rd;
   assign win_data_p0 = mem_gnt_p0 ? mem_data : alu_data;

   assign iss_wr = iss_v && (iss_rd != '0);
   assign iss_ok = !busy[iss_rd];

   // Set is applied after clear so a re-issue on the committing edge stays busy
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (rf_we)  busy_clr[rf_wa]  = 1'b1;
      if (iss_wr) busy_set[iss_rd] = 1'b1;
   end

   // Stage p1: registered write port and scoreboard state
   always_ff @(posedge clk) begin
      if (rst) begin
         pref_mem <= 1'b1;
         rf_we    <= 1'b0;
         rf_wa    <= '0;
         rf_wd    <= '0;
         busy     <= '0;
         waw_err  <= 1'b0;
      end else begin
         if (vld_p0) begin
            pref_mem <= alu_gnt_p0;
            rf_wa    <= win_rd_p0;
            rf_wd    <= win_data_p0;
         end
         rf_we <= vld_p0 && (win_rd_p0 != '0);
         busy  <= ((busy & ~busy_clr) | busy_set) & BUSY_MASK;
         if (iss_wr && busy[iss_rd])
            waw_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile8_wb_arbiter.sv
// Randomized scoreboard bench for regfile8_wb_arbiter with directed warm-up.
module tb_regfile8_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          iss_v;
   logic [AW-1:0] iss_rd;
   logic          iss_ok;
   logic [7:0]    busy;
   logic          waw_err;
   logic          alu_valid, mem_valid;
   logic [AW-1:0] alu_rd, mem_rd;
   logic [DW-1:0] alu_data, mem_data;
   logic          alu_ready, mem_ready;
   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;

   regfile8_wb_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .iss_v(iss_v), .iss_rd(iss_rd), .iss_ok(iss_ok),
      .busy(busy), .waw_err(waw_err),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      int            cyc;
   } wr_t;

   wr_t exp_q[$];
   int  total = 0;
   int  fails = 0;
   int  cyc   = 0;

   // stimulus-side request state
   logic          r;
   logic          a_v, m_v, i_v;
   logic [AW-1:0] a_rd, m_rd, i_rd;
   logic [DW-1:0] a_d, m_d;

   // reference model state
   logic [7:0]    bm;
   logic          wm;
   logic          last_alu;
   logic          commit_v;
   logic [AW-1:0] commit_rd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle: drive at negedge, check combinational/registered state, then
   // advance the model across the coming rising edge.
   task automatic step();
      logic eg_a, eg_m;
      wr_t  w;
      rst = r;
      alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
      mem_valid = m_v; mem_rd = m_rd; mem_data = m_d;
      iss_v = i_v; iss_rd = i_rd;
      #1;
      if (r) begin
         eg_a = 1'b0; eg_m = 1'b0;
      end else if (a_v && m_v) begin
         eg_m = last_alu; eg_a = !last_alu;
      end else begin
         eg_a = a_v; eg_m = m_v;
      end
      chk("alu_ready", 64'(alu_ready), 64'(eg_a));
      chk("mem_ready", 64'(mem_ready), 64'(eg_m));
      chk("busy", 64'(busy), 64'(bm));
      chk("iss_ok", 64'(iss_ok), 64'(!bm[i_rd]));
      chk("waw_err", 64'(waw_err), 64'(wm));
      if (r) begin
         bm = '0; wm = 1'b0; last_alu = 1'b1; commit_v = 1'b0;
      end else begin
         if (i_v && i_rd != 0 && bm[i_rd]) wm = 1'b1;
         if (commit_v) bm[commit_rd] = 1'b0;
         if (i_v && i_rd != 0) bm[i_rd] = 1'b1;
         commit_v = 1'b0;
         if (eg_a || eg_m) begin
            w.wa = eg_a ? a_rd : m_rd;
            w.wd = eg_a ? a_d  : m_d;
            w.cyc = cyc + 1;
            last_alu = eg_a;
            if (w.wa != 0) begin
               exp_q.push_back(w);
               commit_v = 1'b1;
               commit_rd = w.wa;
            end
            if (eg_a) a_v = 1'b0; else m_v = 1'b0;
         end
      end
      i_v = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // Monitor: every registered write must match the next expected one in order and cycle
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(rf_wa), 64'hFFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("rf_wa", 64'(rf_wa), 64'(e.wa));
            chk("rf_wd", 64'(rf_wd), 64'(e.wd));
            chk("write_cycle", 64'(cyc), 64'(e.cyc));
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         wr_t e;
         e = exp_q.pop_front();
         chk("missing_write", 64'(rf_we), 64'd1);
      end
   end

   initial begin
      int alu_list[$];
      int mem_list[$];
      r = 1'b1; a_v = 0; m_v = 0; i_v = 0;
      a_rd = 0; m_rd = 0; i_rd = 0; a_d = 0; m_d = 0;
      bm = '0; wm = 0; last_alu = 1; commit_v = 0; commit_rd = 0;
      rst = 1; alu_valid = 0; mem_valid = 0; iss_v = 0;
      alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0; iss_rd = 0;
      @(negedge clk);

      // reset, then idle
      step(); step();
      r = 1'b0;
      step(); step();

      // single ALU writeback
      a_v = 1; a_rd = 3; a_d = 32'hDEADBEEF;
      step(); step(); step();

      // back-to-back contention: alternation starting with mem
      alu_list = '{1, 2, 3, 4};
      mem_list = '{5, 6, 7};
      for (int k = 0; k < 8; k++) begin
         if (!a_v && alu_list.size() > 0) begin
            a_v = 1; a_rd = AW'(alu_list.pop_front()); a_d = $urandom;
         end
         if (!m_v && mem_list.size() > 0) begin
            m_v = 1; m_rd = AW'(mem_list.pop_front()); m_d = $urandom;
         end
         step();
      end
      step(); step();

      // scoreboard lifetime of rd 5
      i_v = 1; i_rd = 5; step();
      i_rd = 5; step();
      m_v = 1; m_rd = 5; m_d = 32'h5555_0005; i_rd = 5; step();
      i_rd = 5; step();
      i_rd = 5; step();

      // same-edge set/clear on rd 2, then WAW
      i_v = 1; i_rd = 2; step();
      a_v = 1; a_rd = 2; a_d = 32'h2222; step();
      i_v = 1; i_rd = 2; step();
      i_v = 1; i_rd = 2; step();
      step(); step(); step();

      // write to r0, then reset with a transfer in flight
      a_v = 1; a_rd = 0; a_d = 32'h1234; step(); step();
      i_v = 1; i_rd = 6; step();
      a_v = 1; a_rd = 6; a_d = 32'h6666; m_v = 1; m_rd = 7; m_d = 32'h7777; step();
      r = 1'b1; step();
      r = 1'b0; m_v = 0; a_v = 0; step(); step();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         if (!a_v && ($urandom % 2 == 0)) begin
            a_v = 1; a_rd = AW'($urandom % 8); a_d = $urandom;
         end
         if (!m_v && ($urandom % 2 == 0)) begin
            m_v = 1; m_rd = AW'($urandom % 8); m_d = $urandom;
         end
         i_v = ($urandom % 3 == 0);
         i_rd = AW'($urandom % 8);
         r = ($urandom % 97 == 0);
         if (r) begin a_v = 0; m_v = 0; end
         step();
      end
      r = 0; a_v = 0; m_v = 0;
      step(); step(); step();
      chk("drain", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
